// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for keypad-facing blocks.
//   KEYPAD_WIDTH - number of raw key lines (one per decimal key)
//   DIGIT_WIDTH  - width of a BCD digit / key index
//   state_e      - keypad_encoder FSM state encoding
package keypad_pkg;

   localparam int unsigned KEYPAD_WIDTH = 10;
   localparam int unsigned DIGIT_WIDTH  = 4;

   typedef enum logic [1:0] {
      StIdle       = 2'd0,
      StDebPress   = 2'd1,
      StHeld       = 2'd2,
      StDebRelease = 2'd3
   } state_e;

endpackage

// File: rtl/onehot_classify.sv
// onehot_classify: combinational population classifier for a key vector.
//   vec    - key lines, bit i high = key i active
//   none   - no bit set
//   single - exactly one bit set
//   multi  - two or more bits set
//   index  - index of the set bit; only meaningful when single is high
module onehot_classify
   import keypad_pkg::*;
(
   input  logic [KEYPAD_WIDTH-1:0] vec,
   output logic                    none,
   output logic                    single,
   output logic                    multi,
   output logic [DIGIT_WIDTH-1:0]  index
);

   logic [3:0] count;

   always_comb begin
      count = '0;
      index = '0;
      for (int i = 0; i < int'(KEYPAD_WIDTH); i++) begin
         if (vec[i]) begin
            count = count + 4'd1;
            index = DIGIT_WIDTH'(i);
         end
      end
   end

   assign none   = (count == 4'd0);
   assign single = (count == 4'd1);
   assign multi  = (count > 4'd1);

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: synchronizes and debounces a raw 10-line decimal keypad and
// emits one BCD digit plus a one-cycle strobe per clean key press.
//   clock       - system clock, rising edge
//   clear       - asynchronous active-high reset
//   keypad      - raw key lines (asynchronous, may bounce)
//   digit       - BCD code of the last accepted key, held until the next accept
//   digit_valid - one-cycle pulse when digit is new
//   key_held    - accepted key not yet fully released (debounced)
//   key_error   - registered flag: synchronized sample has more than one key set
module keypad_encoder
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                    clock,
   input  logic                    clear,
   input  logic [KEYPAD_WIDTH-1:0] keypad,
   output logic [DIGIT_WIDTH-1:0]  digit,
   output logic                    digit_valid,
   output logic                    key_held,
   output logic                    key_error
);

   localparam logic [7:0] CntLimit = 8'(DEBOUNCE_CYCLES);

   logic [KEYPAD_WIDTH-1:0] sync_meta, sample;
   logic                    is_none, is_single, is_multi;
   logic [DIGIT_WIDTH-1:0]  idx;
   logic                    match;

   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [DIGIT_WIDTH-1:0]  cand_q, cand_d;
   logic                    accept;

   logic [DIGIT_WIDTH-1:0]  digit_q, digit_d;
   logic                    valid_q, valid_d;
   logic                    held_q, held_d;
   logic                    error_q, error_d;

   // Two-flop synchronizer; nothing downstream looks at keypad directly.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         sync_meta <= '0;
         sample    <= '0;
      end else begin
         sync_meta <= keypad;
         sample    <= sync_meta;
      end
   end

   onehot_classify u_classify (
      .vec    (sample),
      .none   (is_none),
      .single (is_single),
      .multi  (is_multi),
      .index  (idx)
   );

   assign match = is_single && (idx == cand_q);

   // State register
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         cand_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (is_single) begin
               cand_d  = idx;
               cnt_d   = 8'd1;
               state_d = StDebPress;
            end
         end
         StDebPress: begin
            if (match) begin
               if (cnt_q == CntLimit) begin
                  accept  = 1'b1;
                  state_d = StHeld;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else begin
               // Bounce, extra key or a different key: abandon this candidate.
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         StHeld: begin
            if (is_none) begin
               cnt_d   = 8'd1;
               state_d = StDebRelease;
            end
         end
         StDebRelease: begin
            if (is_none) begin
               if (cnt_q == CntLimit) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else begin
               state_d = StHeld;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic: next values for the registered outputs.
   always_comb begin
      digit_d = accept ? cand_q : digit_q;
      valid_d = accept;
      held_d  = (state_d == StHeld) || (state_d == StDebRelease);
      error_d = is_multi;
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         digit_q <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         digit_q <= digit_d;
         valid_q <= valid_d;
         held_q  <= held_d;
         error_q <= error_d;
      end
   end

   assign digit       = digit_q;
   assign digit_valid = valid_q;
   assign key_held    = held_q;
   assign key_error   = error_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder (DEBOUNCE_CYCLES = 4).
// Stimulus changes inputs 1ns after a rising edge; cycle number c is the count
// of rising edges so far, so a key set at cycle c is first sampled at edge c+1
// and its strobe is expected to be visible at cycle c+7.
module tb_keypad_encoder;

   localparam int DEB = 4;

   typedef struct {
      int         digit;
      int         cycle;
   } strobe_t;

   // sel: 0 key_held, 1 key_error, 2 digit, 3 digit_valid
   typedef struct {
      int         sel;
      int         cycle;
      logic [3:0] value;
   } probe_t;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic [9:0] keypad = '0;
   logic [3:0] digit;
   logic       digit_valid;
   logic       key_held;
   logic       key_error;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   bit done = 1'b0;

   strobe_t strobe_q[$];
   probe_t  probe_q[$];

   keypad_encoder #(
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clock       (clock),
      .clear       (clear),
      .keypad      (keypad),
      .digit       (digit),
      .digit_valid (digit_valid),
      .key_held    (key_held),
      .key_error   (key_error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_strobe(input int d, input int c);
      strobe_t s;
      s.digit = d;
      s.cycle = c;
      strobe_q.push_back(s);
   endtask

   task automatic probe(input int sel, input int c, input logic [3:0] v);
      probe_t p;
      p.sel   = sel;
      p.cycle = c;
      p.value = v;
      probe_q.push_back(p);
   endtask

   function automatic logic [9:0] key(input int k);
      logic [9:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Press key k for hold cycles, release, then idle for gap cycles.
   task automatic press(input int k, input int hold, input int gap);
      int c0;
      keypad = key(k);
      c0 = cyc;
      expect_strobe(k, c0 + DEB + 3);
      tick(hold);
      keypad = '0;
      tick(gap);
   endtask

   // Monitor / scoreboard
   always @(negedge clock) begin
      if (digit_valid) begin
         vectors++;
         if (strobe_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: got digit %0d at cycle %0d, required no strobe",
                     digit, cyc);
         end else begin
            strobe_t s;
            s = strobe_q.pop_front();
            if (digit !== 4'(s.digit) || cyc != s.cycle) begin
               miscompares++;
               $display("FAIL strobe: got digit %0d at cycle %0d, required digit %0d at cycle %0d",
                        digit, cyc, s.digit, s.cycle);
            end
         end
      end
      while (probe_q.size() > 0 && probe_q[0].cycle <= cyc) begin
         probe_t     p;
         logic [3:0] act;
         p = probe_q.pop_front();
         vectors++;
         case (p.sel)
            0:       act = {3'b0, key_held};
            1:       act = {3'b0, key_error};
            2:       act = digit;
            default: act = {3'b0, digit_valid};
         endcase
         if (p.cycle != cyc || act !== p.value) begin
            miscompares++;
            $display("FAIL probe_sel%0d: got %0d at cycle %0d, required %0d at cycle %0d",
                     p.sel, act, cyc, p.value, p.cycle);
         end
      end
      if (done) begin
         vectors++;
         if (strobe_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_strobes: got %0d outstanding, required 0", strobe_q.size());
         end
         vectors++;
         if (probe_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_probes: got %0d outstanding, required 0", probe_q.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, r, last_on;

      // Reset values
      tick(2);
      probe(0, cyc, 4'd0);
      probe(1, cyc, 4'd0);
      probe(2, cyc, 4'd0);
      probe(3, cyc, 4'd0);
      tick(1);
      clear = 1'b0;
      tick(2);

      // Clean press of key 2, held 20 cycles
      c = cyc;
      keypad = key(2);
      expect_strobe(2, c + 7);
      probe(0, c + 6, 4'd0);
      probe(0, c + 7, 4'd1);
      probe(3, c + 8, 4'd0);
      probe(2, c + 8, 4'd2);
      tick(20);
      r = cyc;
      keypad = '0;
      probe(0, r + 6, 4'd1);
      probe(0, r + 7, 4'd0);
      probe(2, r + 7, 4'd2);
      tick(12);

      // Bounce on key 5: toggles every 2 cycles, then stays pressed
      last_on = cyc;
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) begin
            keypad  = key(5);
            last_on = cyc;
         end else begin
            keypad = '0;
         end
         tick(2);
      end
      expect_strobe(5, last_on + 7);
      tick(20);
      keypad = '0;
      tick(12);

      // Multi-key 3+9, then release 3 so 9 stands alone
      c = cyc;
      keypad = key(3) | key(9);
      probe(1, c + 2, 4'd0);
      probe(1, c + 3, 4'd1);
      tick(10);
      c = cyc;
      keypad = key(9);
      probe(1, c + 2, 4'd1);
      probe(1, c + 3, 4'd0);
      expect_strobe(9, c + 7);
      tick(20);
      keypad = '0;
      tick(12);

      // Long hold of 9, short release, press 9 again
      press(9, 200, 10);
      press(9, 20, 12);

      // Clear during DEB_PRESS of key 7, key held through clear release
      c = cyc;
      keypad = key(7);
      tick(5);
      clear = 1'b1;
      #1;
      probe(0, cyc, 4'd0);
      probe(1, cyc, 4'd0);
      probe(2, cyc, 4'd0);
      probe(3, cyc, 4'd0);
      tick(2);
      clear = 1'b0;
      c = cyc;
      expect_strobe(7, c + 7);
      probe(2, c + 6, 4'd0);
      probe(2, c + 7, 4'd7);
      tick(20);
      keypad = '0;
      tick(12);

      // Digit sequence 2, 5, 9, 9, 9
      press(2, 110, 110);
      press(5, 110, 110);
      press(9, 110, 110);
      press(9, 110, 110);
      press(9, 110, 110);
      probe(2, cyc, 4'd9);

      tick(2);
      done = 1'b1;
   end

endmodule
